idu_is_pipe4_sched: RTL and testbench

Issue scheduler for pipe4, the single-source, immediate-carrying execution pipe. It buffers dispatched pipe4 instructions in an 8-entry queue and tracks readiness of psrc1 by snooping the ex and cdb writeback buses. Each cycle it selects the oldest ready entry and drives it into the pipe4 register-read stage, which bypasses from those same buses. At most one instruction is dispatched in and one issued out per cycle.

---
 rtl/idu_is_pipe4_sched_if.sv | 77 +++++++
 rtl/idu_is_pipe4_sched.sv | 141 ++++++++++++++
 tb/tb_idu_is_pipe4_sched.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/idu_is_pipe4_sched_if.sv
// Dispatch, writeback-snoop and issue signals of the pipe4 issue scheduler.
// master: surrounding pipeline; slave: the scheduler itself.
interface idu_is_pipe4_sched_if;
  logic        rtu_global_flush;
  logic        dis_pipe4_vld;
  logic [4:0]  dis_pipe4_iid;
  logic [6:0]  dis_pipe4_opcode;
  logic        dis_pipe4_psrc1_vld;
  logic [5:0]  dis_pipe4_psrc1;
  logic        dis_pipe4_psrc1_rdy;
  logic        dis_pipe4_imm_vld;
  logic [63:0] dis_pipe4_imm;
  logic        sched_pipe4_full;
  logic [3:0]  sched_pipe4_cnt;
  logic        exu_idu_is_alu_ex_vld;
  logic [5:0]  exu_idu_is_alu_ex_preg;
  logic        exu_idu_is_mxu_ex_vld;
  logic [5:0]  exu_idu_is_mxu_ex_preg;
  logic        exu_idu_is_div_ex_vld;
  logic [5:0]  exu_idu_is_div_ex_preg;
  logic        exu_idu_is_lsu_ex_vld;
  logic [5:0]  exu_idu_is_lsu_ex_preg;
  logic        exu_idu_is_alu_cdb_vld;
  logic [5:0]  exu_idu_is_alu_cdb_preg;
  logic        exu_idu_is_mxu_cdb_vld;
  logic [5:0]  exu_idu_is_mxu_cdb_preg;
  logic        exu_idu_is_div_cdb_vld;
  logic [5:0]  exu_idu_is_div_cdb_preg;
  logic        exu_idu_is_lsu_cdb_vld;
  logic [5:0]  exu_idu_is_lsu_cdb_preg;
  logic        lsu_idu_pipe4_stall;
  logic        idu_idu_rf_pipe4_vld;
  logic [4:0]  idu_idu_rf_pipe4_iid;
  logic [6:0]  idu_idu_rf_pipe4_opcode;
  logic        idu_idu_rf_pipe4_psrc1_vld;
  logic [5:0]  idu_idu_rf_pipe4_psrc1;
  logic        idu_idu_rf_pipe4_imm_vld;
  logic [63:0] idu_idu_rf_pipe4_imm;

  modport master (
    output rtu_global_flush, dis_pipe4_vld, dis_pipe4_iid, dis_pipe4_opcode,
           dis_pipe4_psrc1_vld, dis_pipe4_psrc1, dis_pipe4_psrc1_rdy,
           dis_pipe4_imm_vld, dis_pipe4_imm,
           exu_idu_is_alu_ex_vld, exu_idu_is_alu_ex_preg,
           exu_idu_is_mxu_ex_vld, exu_idu_is_mxu_ex_preg,
           exu_idu_is_div_ex_vld, exu_idu_is_div_ex_preg,
           exu_idu_is_lsu_ex_vld, exu_idu_is_lsu_ex_preg,
           exu_idu_is_alu_cdb_vld, exu_idu_is_alu_cdb_preg,
           exu_idu_is_mxu_cdb_vld, exu_idu_is_mxu_cdb_preg,
           exu_idu_is_div_cdb_vld, exu_idu_is_div_cdb_preg,
           exu_idu_is_lsu_cdb_vld, exu_idu_is_lsu_cdb_preg,
           lsu_idu_pipe4_stall,
    input  sched_pipe4_full, sched_pipe4_cnt,
           idu_idu_rf_pipe4_vld, idu_idu_rf_pipe4_iid, idu_idu_rf_pipe4_opcode,
           idu_idu_rf_pipe4_psrc1_vld, idu_idu_rf_pipe4_psrc1,
           idu_idu_rf_pipe4_imm_vld, idu_idu_rf_pipe4_imm
  );

  modport slave (
    input  rtu_global_flush, dis_pipe4_vld, dis_pipe4_iid, dis_pipe4_opcode,
           dis_pipe4_psrc1_vld, dis_pipe4_psrc1, dis_pipe4_psrc1_rdy,
           dis_pipe4_imm_vld, dis_pipe4_imm,
           exu_idu_is_alu_ex_vld, exu_idu_is_alu_ex_preg,
           exu_idu_is_mxu_ex_vld, exu_idu_is_mxu_ex_preg,
           exu_idu_is_div_ex_vld, exu_idu_is_div_ex_preg,
           exu_idu_is_lsu_ex_vld, exu_idu_is_lsu_ex_preg,
           exu_idu_is_alu_cdb_vld, exu_idu_is_alu_cdb_preg,
           exu_idu_is_mxu_cdb_vld, exu_idu_is_mxu_cdb_preg,
           exu_idu_is_div_cdb_vld, exu_idu_is_div_cdb_preg,
           exu_idu_is_lsu_cdb_vld, exu_idu_is_lsu_cdb_preg,
           lsu_idu_pipe4_stall,
    output sched_pipe4_full, sched_pipe4_cnt,
           idu_idu_rf_pipe4_vld, idu_idu_rf_pipe4_iid, idu_idu_rf_pipe4_opcode,
           idu_idu_rf_pipe4_psrc1_vld, idu_idu_rf_pipe4_psrc1,
           idu_idu_rf_pipe4_imm_vld, idu_idu_rf_pipe4_imm
  );
endinterface

// File: rtl/idu_is_pipe4_sched.sv
// Pipe4 issue scheduler: 8-entry queue, psrc1 wakeup from ex/cdb buses,
// oldest-ready select through an age matrix, one dispatch and one issue per cycle.
module idu_is_pipe4_sched (
  input  logic                       clk,
  input  logic                       rst_clk,
  idu_is_pipe4_sched_if.slave        bus
);
  logic [7:0]  vld_q, rdy_q, psrc1_vld_q, imm_vld_q;
  logic [4:0]  iid_q    [8];
  logic [6:0]  opcode_q [8];
  logic [5:0]  psrc1_q  [8];
  logic [63:0] imm_q    [8];
  logic [7:0]  age_q    [8];
  logic [3:0]  cnt_q;

  logic [7:0]  wb_vld;
  logic [5:0]  wb_preg [8];
  logic [7:0]  hit, cand, grant;
  logic        dis_hit, blocked, alloc, issue_vld, full;
  logic [2:0]  alloc_idx;
  logic [4:0]  iss_iid;
  logic [6:0]  iss_opcode;
  logic        iss_psrc1_vld, iss_imm_vld;
  logic [5:0]  iss_psrc1;
  logic [63:0] iss_imm;

  assign wb_vld = {bus.exu_idu_is_lsu_cdb_vld, bus.exu_idu_is_div_cdb_vld,
                   bus.exu_idu_is_mxu_cdb_vld, bus.exu_idu_is_alu_cdb_vld,
                   bus.exu_idu_is_lsu_ex_vld,  bus.exu_idu_is_div_ex_vld,
                   bus.exu_idu_is_mxu_ex_vld,  bus.exu_idu_is_alu_ex_vld};
  assign wb_preg[0] = bus.exu_idu_is_alu_ex_preg;
  assign wb_preg[1] = bus.exu_idu_is_mxu_ex_preg;
  assign wb_preg[2] = bus.exu_idu_is_div_ex_preg;
  assign wb_preg[3] = bus.exu_idu_is_lsu_ex_preg;
  assign wb_preg[4] = bus.exu_idu_is_alu_cdb_preg;
  assign wb_preg[5] = bus.exu_idu_is_mxu_cdb_preg;
  assign wb_preg[6] = bus.exu_idu_is_div_cdb_preg;
  assign wb_preg[7] = bus.exu_idu_is_lsu_cdb_preg;

  // Tag compare of every bus against every stored psrc1 and the incoming one.
  always_comb begin
    hit     = '0;
    dis_hit = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (wb_vld[b] && wb_preg[b] == bus.dis_pipe4_psrc1) dis_hit = 1'b1;
      for (int e = 0; e < 8; e++)
        if (wb_vld[b] && wb_preg[b] == psrc1_q[e]) hit[e] = 1'b1;
    end
  end

  always_comb begin
    alloc_idx = '0;
    for (int e = 7; e >= 0; e--)
      if (!vld_q[e]) alloc_idx = 3'(e);
  end

  // An entry wins when no other candidate is older than it.
  assign cand = vld_q & rdy_q;
  always_comb begin
    grant   = '0;
    blocked = 1'b0;
    for (int i = 0; i < 8; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < 8; j++)
        if (cand[j] && age_q[j][i]) blocked = 1'b1;
      grant[i] = cand[i] & ~blocked;
    end
  end

  assign full      = (cnt_q == 4'd8);
  assign alloc     = bus.dis_pipe4_vld & ~full & ~bus.rtu_global_flush;
  assign issue_vld = (|cand) & ~bus.lsu_idu_pipe4_stall & ~bus.rtu_global_flush;

  always_comb begin
    iss_iid       = '0;
    iss_opcode    = '0;
    iss_psrc1_vld = 1'b0;
    iss_psrc1     = '0;
    iss_imm_vld   = 1'b0;
    iss_imm       = '0;
    for (int e = 0; e < 8; e++) begin
      if (issue_vld && grant[e]) begin
        iss_iid       = iss_iid       | iid_q[e];
        iss_opcode    = iss_opcode    | opcode_q[e];
        iss_psrc1_vld = iss_psrc1_vld | psrc1_vld_q[e];
        iss_psrc1     = iss_psrc1     | psrc1_q[e];
        iss_imm_vld   = iss_imm_vld   | imm_vld_q[e];
        iss_imm       = iss_imm       | imm_q[e];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      vld_q       <= '0;
      rdy_q       <= '0;
      psrc1_vld_q <= '0;
      imm_vld_q   <= '0;
      cnt_q       <= '0;
      for (int e = 0; e < 8; e++) begin
        iid_q[e]    <= '0;
        opcode_q[e] <= '0;
        psrc1_q[e]  <= '0;
        imm_q[e]    <= '0;
        age_q[e]    <= '0;
      end
    end else if (bus.rtu_global_flush) begin
      vld_q <= '0;
      rdy_q <= '0;
      cnt_q <= '0;
    end else begin
      for (int e = 0; e < 8; e++)
        if (vld_q[e] && psrc1_vld_q[e] && hit[e]) rdy_q[e] <= 1'b1;
      vld_q <= (vld_q & ~(issue_vld ? grant : 8'h00))
             | (alloc ? (8'h01 << alloc_idx) : 8'h00);
      cnt_q <= cnt_q + {3'b000, alloc} - {3'b000, issue_vld};
      if (alloc) begin
        iid_q[alloc_idx]       <= bus.dis_pipe4_iid;
        opcode_q[alloc_idx]    <= bus.dis_pipe4_opcode;
        psrc1_vld_q[alloc_idx] <= bus.dis_pipe4_psrc1_vld;
        psrc1_q[alloc_idx]     <= bus.dis_pipe4_psrc1;
        imm_vld_q[alloc_idx]   <= bus.dis_pipe4_imm_vld;
        imm_q[alloc_idx]       <= bus.dis_pipe4_imm;
        rdy_q[alloc_idx]       <= ~bus.dis_pipe4_psrc1_vld | bus.dis_pipe4_psrc1_rdy | dis_hit;
        // New entry is younger than every valid entry.
        for (int j = 0; j < 8; j++) age_q[j][alloc_idx] <= vld_q[j];
        age_q[alloc_idx] <= '0;
      end
    end
  end

  assign bus.sched_pipe4_full           = full;
  assign bus.sched_pipe4_cnt            = cnt_q;
  assign bus.idu_idu_rf_pipe4_vld       = issue_vld;
  assign bus.idu_idu_rf_pipe4_iid       = iss_iid;
  assign bus.idu_idu_rf_pipe4_opcode    = iss_opcode;
  assign bus.idu_idu_rf_pipe4_psrc1_vld = iss_psrc1_vld;
  assign bus.idu_idu_rf_pipe4_psrc1     = iss_psrc1;
  assign bus.idu_idu_rf_pipe4_imm_vld   = iss_imm_vld;
  assign bus.idu_idu_rf_pipe4_imm       = iss_imm;
endmodule

// File: tb/tb_idu_is_pipe4_sched.sv
// Bench for idu_is_pipe4_sched: age-ordered queue reference model feeding a
// scoreboard, with directed scenarios followed by random traffic.
module tb_idu_is_pipe4_sched;
  logic clk = 1'b0;
  logic rst_clk = 1'b0;
  always #5 clk = ~clk;

  idu_is_pipe4_sched_if bus ();
  idu_is_pipe4_sched dut (.clk(clk), .rst_clk(rst_clk), .bus(bus.slave));

  typedef struct packed {
    logic [4:0]  iid;
    logic [6:0]  opc;
    logic        pv;
    logic [5:0]  p;
    logic        iv;
    logic [63:0] imm;
    logic        rdy;
  } ent_t;

  ent_t mq[$];
  ent_t exp_q[$];
  int checks = 0;
  int passes = 0;

  logic        s_dvld, s_pv, s_prdy, s_iv, s_stall, s_flush;
  logic [4:0]  s_iid;
  logic [6:0]  s_opc;
  logic [5:0]  s_p;
  logic [63:0] s_imm;
  logic        s_wv [8];
  logic [5:0]  s_wp [8];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  function automatic bit wb_hit(input logic [5:0] p);
    bit h = 1'b0;
    for (int b = 0; b < 8; b++) if (s_wv[b] && s_wp[b] == p) h = 1'b1;
    return h;
  endfunction

  task automatic set_idle();
    s_dvld = 0; s_pv = 0; s_prdy = 0; s_iv = 0; s_stall = 0; s_flush = 0;
    s_iid = '0; s_opc = '0; s_p = '0; s_imm = '0;
    for (int b = 0; b < 8; b++) begin s_wv[b] = 0; s_wp[b] = '0; end
  endtask

  task automatic disp(input logic [4:0] iid, input logic pv, input logic [5:0] p, input logic prdy);
    s_dvld = 1; s_iid = iid; s_pv = pv; s_p = p; s_prdy = prdy;
    s_opc = 7'($urandom); s_iv = 1'($urandom); s_imm = {$urandom, $urandom};
  endtask

  task automatic drive();
    bus.dis_pipe4_vld = s_dvld;   bus.dis_pipe4_iid = s_iid;  bus.dis_pipe4_opcode = s_opc;
    bus.dis_pipe4_psrc1_vld = s_pv; bus.dis_pipe4_psrc1 = s_p; bus.dis_pipe4_psrc1_rdy = s_prdy;
    bus.dis_pipe4_imm_vld = s_iv; bus.dis_pipe4_imm = s_imm;
    bus.lsu_idu_pipe4_stall = s_stall; bus.rtu_global_flush = s_flush;
    bus.exu_idu_is_alu_ex_vld = s_wv[0];  bus.exu_idu_is_alu_ex_preg = s_wp[0];
    bus.exu_idu_is_mxu_ex_vld = s_wv[1];  bus.exu_idu_is_mxu_ex_preg = s_wp[1];
    bus.exu_idu_is_div_ex_vld = s_wv[2];  bus.exu_idu_is_div_ex_preg = s_wp[2];
    bus.exu_idu_is_lsu_ex_vld = s_wv[3];  bus.exu_idu_is_lsu_ex_preg = s_wp[3];
    bus.exu_idu_is_alu_cdb_vld = s_wv[4]; bus.exu_idu_is_alu_cdb_preg = s_wp[4];
    bus.exu_idu_is_mxu_cdb_vld = s_wv[5]; bus.exu_idu_is_mxu_cdb_preg = s_wp[5];
    bus.exu_idu_is_div_cdb_vld = s_wv[6]; bus.exu_idu_is_div_cdb_preg = s_wp[6];
    bus.exu_idu_is_lsu_cdb_vld = s_wv[7]; bus.exu_idu_is_lsu_cdb_preg = s_wp[7];
  endtask

  // One clock of stimulus: drive, check occupancy, predict issue, advance model.
  task automatic do_cycle();
    int   sel;
    bit   acc;
    ent_t e;
    @(negedge clk);
    drive();
    #1;
    sel = -1;
    if (!s_flush && !s_stall)
      for (int i = 0; i < mq.size(); i++) if (sel < 0 && mq[i].rdy) sel = i;
    check("cnt", 96'(bus.sched_pipe4_cnt), 96'(mq.size()));
    check("full", 96'(bus.sched_pipe4_full), 96'(mq.size() == 8));
    check("issue_vld", 96'(bus.idu_idu_rf_pipe4_vld), 96'(sel >= 0));
    if (sel >= 0) exp_q.push_back(mq[sel]);
    if (s_flush) mq.delete();
    else begin
      acc = s_dvld && (mq.size() < 8);
      if (sel >= 0) mq.delete(sel);
      for (int i = 0; i < mq.size(); i++) if (mq[i].pv && wb_hit(mq[i].p)) mq[i].rdy = 1'b1;
      if (acc) begin
        e.iid = s_iid; e.opc = s_opc; e.pv = s_pv; e.p = s_p; e.iv = s_iv; e.imm = s_imm;
        e.rdy = !s_pv || s_prdy || wb_hit(s_p);
        mq.push_back(e);
      end
    end
  endtask

  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (bus.idu_idu_rf_pipe4_vld) begin
        if (exp_q.size() == 0) check("issue_unexpected", 96'(bus.idu_idu_rf_pipe4_vld), 96'(0));
        else begin
          e = exp_q.pop_front();
          check("issue_iid",   96'(bus.idu_idu_rf_pipe4_iid), 96'(e.iid));
          check("issue_opc",   96'(bus.idu_idu_rf_pipe4_opcode), 96'(e.opc));
          check("issue_pv",    96'(bus.idu_idu_rf_pipe4_psrc1_vld), 96'(e.pv));
          check("issue_psrc1", 96'(bus.idu_idu_rf_pipe4_psrc1), 96'(e.p));
          check("issue_iv",    96'(bus.idu_idu_rf_pipe4_imm_vld), 96'(e.iv));
          check("issue_imm",   96'(bus.idu_idu_rf_pipe4_imm), 96'(e.imm));
        end
      end else begin
        check("idle_fields", 96'({bus.idu_idu_rf_pipe4_iid, bus.idu_idu_rf_pipe4_opcode,
              bus.idu_idu_rf_pipe4_psrc1_vld, bus.idu_idu_rf_pipe4_psrc1,
              bus.idu_idu_rf_pipe4_imm_vld, bus.idu_idu_rf_pipe4_imm}), 96'(0));
      end
    end
  end

  initial begin
    set_idle();
    drive();
    repeat (2) @(negedge clk);
    rst_clk = 1'b1;

    // Ready dispatch issues the next cycle.
    disp(5'd3, 1, 6'd5, 1); do_cycle();
    set_idle(); repeat (2) do_cycle();

    // Younger ready entry bypasses older waiting one; cdb wakeup releases it.
    disp(5'd1, 1, 6'd12, 0); do_cycle();
    disp(5'd2, 1, 6'd20, 1); do_cycle();
    set_idle(); repeat (2) do_cycle();
    s_wv[4] = 1; s_wp[4] = 6'd12; do_cycle();
    set_idle(); repeat (2) do_cycle();

    // Fill, dispatch while full, wake one, refill the freed slot.
    for (int i = 0; i < 8; i++) begin disp(5'(8 + i), 1, 6'(30 + i), 0); do_cycle(); end
    disp(5'd20, 1, 6'd50, 1); do_cycle();
    set_idle(); s_wv[1] = 1; s_wp[1] = 6'd33; do_cycle();
    set_idle(); do_cycle();
    disp(5'd21, 1, 6'd40, 1); do_cycle();
    set_idle(); repeat (2) do_cycle();
    s_flush = 1; do_cycle();

    // Stall held over three ready entries.
    set_idle(); s_stall = 1;
    for (int i = 0; i < 3; i++) begin disp(5'(24 + i), 1, 6'(i), 1); s_stall = 1; do_cycle(); end
    set_idle(); s_stall = 1; repeat (4) do_cycle();
    set_idle(); repeat (4) do_cycle();

    // Flush with a concurrent dispatch.
    for (int i = 0; i < 6; i++) begin disp(5'(i), 1, 6'(40 + i), 1'(i & 1)); s_stall = 1; do_cycle(); end
    set_idle(); disp(5'd31, 0, 6'd0, 1); s_flush = 1; do_cycle();
    set_idle(); repeat (3) do_cycle();

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 5; i++) begin disp(5'(i), 1, 6'(i), 1); s_stall = 1; do_cycle(); end
    set_idle(); s_stall = 1; do_cycle();
    @(negedge clk); #3;
    rst_clk = 1'b0;
    #1;
    check("rst_cnt",  96'(bus.sched_pipe4_cnt), 96'(0));
    check("rst_full", 96'(bus.sched_pipe4_full), 96'(0));
    check("rst_vld",  96'(bus.idu_idu_rf_pipe4_vld), 96'(0));
    mq.delete();
    exp_q.delete();
    @(negedge clk); #3;
    rst_clk = 1'b1;
    set_idle();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      set_idle();
      if ($urandom_range(99) < 60)
        disp(5'($urandom), 1'($urandom_range(99) < 80), 6'($urandom_range(15)), 1'($urandom_range(99) < 30));
      for (int b = 0; b < 8; b++) begin
        s_wv[b] = ($urandom_range(99) < 15);
        s_wp[b] = 6'($urandom_range(15));
      end
      s_stall = ($urandom_range(99) < 25);
      s_flush = ($urandom_range(99) < 2);
      do_cycle();
    end
    set_idle(); repeat (10) do_cycle();
    s_flush = 1; do_cycle();
    set_idle(); repeat (2) do_cycle();
    @(negedge clk); #3;
    check("scoreboard_drain", 96'(exp_q.size()), 96'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
